// File: rtl/msk_tweak_pkg.sv
// msk_tweak_pkg
// Shared definitions for the masked TK1 rewind engine.
// Holds the byte count, byte width, default maximum step count, the inverse
// and forward SKINNY tweakey byte-index tables (LSB byte = index 0) and the
// FSM state type used by msk_tweak_rewind.
// The forward table is the exact inverse of the rewind table; it exists so
// that verification code can push a state forward and then rewind it.
package msk_tweak_pkg;

  localparam int NBYTES     = 16;
  localparam int W          = 8;
  localparam int NR_MAX_DEF = 40;

  // Rewind step: new byte k takes old byte INV_SRC[k], in every share.
  localparam int unsigned INV_SRC [NBYTES] = '{
    14, 10, 12, 9, 8, 11, 15, 13,
    0, 1, 2, 3, 4, 5, 6, 7
  };

  // Forward step: new byte k takes old byte FWD_SRC[k]; FWD_SRC[INV_SRC[k]] == k.
  localparam int unsigned FWD_SRC [NBYTES] = '{
    8, 9, 10, 11, 12, 13, 14, 15,
    4, 3, 1, 5, 2, 7, 0, 6
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_e;

endpackage

// File: rtl/msk_tweak_perm_inv.sv
// msk_tweak_perm_inv
// Purely combinational inverse SKINNY tweakey byte permutation.
// Each byte slice is d*W bits wide with the d shares interleaved inside it,
// so moving a whole slice moves every share of that byte identically and the
// shares are never combined with each other.
// Ports:
//   i_state  : d*128-bit masked tweakey, byte k at slice k
//   o_update : d*128-bit state after one inverse step
module msk_tweak_perm_inv
  import msk_tweak_pkg::*;
#(
  parameter int d = 2
) (
  input  logic [d*NBYTES*W-1:0] i_state,
  output logic [d*NBYTES*W-1:0] o_update
);

  localparam int SLICE = d * W;

  // Each output slice is a straight wire from the source slice named by the
  // rewind table; no logic, only routing.
  for (genvar k = 0; k < NBYTES; k++) begin : g_byte
    assign o_update[k*SLICE +: SLICE] = i_state[INV_SRC[k]*SLICE +: SLICE];
  end

endmodule

// File: rtl/msk_tweak_rewind.sv
// msk_tweak_rewind
// Masked TK1 rewind engine for Romulus-N decryption and tag paths.
// Loads a d-share masked 128-bit tweakey, applies the inverse tweakey byte
// permutation a programmable number of times and holds the result behind a
// valid/ready handshake.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : load handshake (in_ready only in IDLE)
//   in_state             : masked tweakey to rewind
//   in_steps             : inverse step count, clamped to NR_MAX
//   out_valid / out_ready: result handshake
//   out_state            : rewound masked tweakey (register output)
//   busy                 : rewinding in progress
// Build option: define MSK_TWEAK_REWIND_DOUBLE_STEP_EN to apply two inverse
// steps per RUN cycle; results are identical, only latency changes.
module msk_tweak_rewind
  import msk_tweak_pkg::*;
#(
  parameter  int d      = 2,
  parameter  int NR_MAX = NR_MAX_DEF,
  localparam int CW     = $clog2(NR_MAX + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [d*NBYTES*W-1:0] in_state,
  input  logic [CW-1:0]         in_steps,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [d*NBYTES*W-1:0] out_state,
  output logic                  busy
);

  localparam int SW = d * NBYTES * W;
  localparam logic [CW-1:0] NR_MAX_C = CW'(NR_MAX);
  localparam logic [CW-1:0] ONE_C    = CW'(1);

  fsm_e          r_fsm;
  fsm_e          w_fsmNext;
  logic [SW-1:0] r_state;
  logic [SW-1:0] w_stateNext;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_countNext;
  logic [CW-1:0] w_stepsClamped;
  logic [SW-1:0] w_perm1;

  // First inverse step, always present.
  msk_tweak_perm_inv #(.d(d)) u_perm1 (
    .i_state  (r_state),
    .o_update (w_perm1)
  );

`ifdef MSK_TWEAK_REWIND_DOUBLE_STEP_EN
  logic [SW-1:0] w_perm2;
  localparam logic [CW-1:0] TWO_C = CW'(2);

  // Second inverse step chained behind the first so a RUN cycle can retire
  // two steps at once.
  msk_tweak_perm_inv #(.d(d)) u_perm2 (
    .i_state  (w_perm1),
    .o_update (w_perm2)
  );
`endif

  // Oversized step requests are clamped at load so the counter never starts
  // above the supported maximum.
  assign w_stepsClamped = (in_steps > NR_MAX_C) ? NR_MAX_C : in_steps;

  // Handshake and status are plain decodes of the FSM register; in_ready is
  // also held low while reset is asserted.
  assign in_ready  = (r_fsm == IDLE) && !rst;
  assign out_valid = (r_fsm == DONE);
  assign busy      = (r_fsm == RUN);
  assign out_state = r_state;

  // Next-state logic. IDLE loads and picks RUN or DONE depending on whether
  // any steps remain; RUN retires one (or two) steps per cycle and moves to
  // DONE on the cycle that consumes the last one; DONE waits for the consumer
  // and never reloads in the same cycle it hands off.
  always_comb begin
    w_fsmNext   = r_fsm;
    w_stateNext = r_state;
    w_countNext = r_count;
    unique case (r_fsm)
      IDLE: begin
        if (in_valid) begin
          w_stateNext = in_state;
          w_countNext = w_stepsClamped;
          w_fsmNext   = (w_stepsClamped == '0) ? DONE : RUN;
        end
      end
      RUN: begin
`ifdef MSK_TWEAK_REWIND_DOUBLE_STEP_EN
        if (r_count >= TWO_C) begin
          w_stateNext = w_perm2;
          w_countNext = r_count - TWO_C;
          if (r_count == TWO_C) begin
            w_fsmNext = DONE;
          end
        end else begin
          w_stateNext = w_perm1;
          w_countNext = r_count - ONE_C;
          w_fsmNext   = DONE;
        end
`else
        w_stateNext = w_perm1;
        w_countNext = r_count - ONE_C;
        if (r_count == ONE_C) begin
          w_fsmNext = DONE;
        end
`endif
      end
      DONE: begin
        if (out_ready) begin
          w_fsmNext = IDLE;
        end
      end
      default: begin
        w_fsmNext = IDLE;
      end
    endcase
  end

  // State, data and counter registers. Reset drops any pending result and
  // clears the held tweakey so no masked data lingers after an abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm   <= IDLE;
      r_state <= '0;
      r_count <= '0;
    end else begin
      r_fsm   <= w_fsmNext;
      r_state <= w_stateNext;
      r_count <= w_countNext;
    end
  end

endmodule
